pc_sequencer: RTL and testbench
===============================

# pc_sequencer

Run-control FSM that sequences the fetch-stage program counter. Drives the PC register's Init, Halt, Branch_abs, Branch_rel_z, Branch_rel_nz and Target inputs. Per-instruction flags come from the decoder. Handles program launch at a selectable start address, multi-cycle load stalls, the halt instruction, and abort, and reports run status plus a cycle count to the test harness.

## Interface
Parameters:
- PROG0_START, 16'd0, start address for Prog_sel=0
- PROG1_START, 16'd0, start address for Prog_sel=1
- PROG2_START, 16'd0, start address for Prog_sel=2
- PROG3_START, 16'd0, start address for Prog_sel=3
- LOAD_LAT, 3, total cycles the PC holds at a load instruction, including its issue cycle; legal range 2..15

Ports:
- CLK  in  1  clock; all state changes on posedge
- RST_N  in  1  reset, asynchronous, active-low
- Start  in  1  launch request, sampled in IDLE/DONE
- Prog_sel  in  2  program select, captured with Start
- Abort  in  1  return to IDLE from any state
- Dec_halt  in  1  current instruction is halt
- Dec_load  in  1  current instruction is a multi-cycle load
- Dec_jump  in  1  absolute jump
- Dec_bz  in  1  relative branch if zero
- Dec_bnz  in  1  relative branch if not zero
- Dec_target  in  16  jump/branch target from decoder
- Init  out  1  to PC: reset PC to 0
- Halt  out  1  to PC: freeze PC
- Branch_abs, Branch_rel_z, Branch_rel_nz  out  1 each  to PC
- Target  out  16  to PC
- Busy  out  1  high in INIT, LAUNCH, RUN, WAIT
- Done  out  1  high in DONE
- Cycle_count  out  16  execution cycles of last/current run

## Operation
- States: IDLE, INIT, LAUNCH, RUN, WAIT, DONE. Reset sets IDLE.
- Output values at reset and in IDLE: Halt=1; Init=0; all branch outputs 0; Target=0; Busy=0; Done=0; Cycle_count=0 on reset only.
- Priority: RST_N > Abort > Start > decode flags.
- IDLE: on Start, capture Prog_sel into sel_q and go to INIT.
- INIT (1 cycle): Init=1, Halt=0. Cycle_count is cleared. Go to LAUNCH.
- LAUNCH (1 cycle): Branch_abs=1, Target = PROGn_START for sel_q. Go to RUN.
- RUN, Dec_halt=1: Halt=1, no branch outputs asserted, Cycle_count increments, go to DONE.
- RUN, Dec_load=1: Halt=1, cnt <= LOAD_LAT-2, go to WAIT.
- RUN, otherwise: Halt=0; Branch_abs=Dec_jump, Branch_rel_z=Dec_bz, Branch_rel_nz=Dec_bnz, combinational pass-through. Target=Dec_target.
- Decoder flag conflicts: Dec_halt beats Dec_load, which beats the branch flags. Only one branch output is asserted at a time, with priority jump > bz > bnz.
- WAIT, cnt != 0: Halt=1, cnt decrements.
- WAIT, cnt == 0: Halt=0, branch outputs 0 (PC+1), go to RUN.
- Outside RUN pass-through, Target is 0 except in LAUNCH.
- DONE: Halt=1, Done=1. Start behaves as in IDLE and clears Done on leaving.
- Cycle_count increments once per cycle in RUN and WAIT. It saturates at 16'hFFFF and holds its value in DONE/IDLE until the next INIT.
- Abort in any state: next state IDLE, Cycle_count held, cnt cleared.
- Start in INIT, LAUNCH, RUN or WAIT is ignored.

## Timing
- Start sampled high at edge t: INIT at t+1, LAUNCH at t+2, first RUN cycle at t+3, PC = PROGn_START in that cycle.
- In RUN, Init/Halt/branch outputs are Mealy, so the PC register acts on the same edge. State, cnt, Done, Busy and Cycle_count are registered.
- A load holds the PC for exactly LAUNCH-independent LOAD_LAT cycles: 1 RUN cycle + (LOAD_LAT-2) WAIT cycles with cnt != 0 + 1 release cycle.
- A halt instruction seen in RUN at edge t gives Done=1 and Busy=0 from t+1.
- Asynchronous reset mid-run forces IDLE outputs immediately, without waiting for a clock.

## Test plan
- Reset, then Start with Prog_sel=2 and PROG2_START=16'h0040 -> Init high 1 cycle, then Branch_abs=1 with Target=0040, then Busy=1 and PC=0040 in the first RUN cycle.
- Straight-line code of 5 non-branch instructions then halt -> Cycle_count=6, Done=1, Halt=1, PC frozen at the halt address.
- Load at PC=0042 with LOAD_LAT=3 -> Halt high 2 cycles, PC at 0042 for exactly 3 cycles, then 0043; Cycle_count reflects all 3.
- Dec_bz and Dec_jump asserted together with Dec_target=16'h0010 -> only Branch_abs=1, Target=0010.
- Abort asserted while in WAIT -> IDLE next cycle, Halt=1, Busy=0, Cycle_count held; a following Start relaunches cleanly.
- RST_N low in RUN between clock edges -> Halt=1, Busy=0, Cycle_count=0 asynchronously; Start pulse during RUN is ignored.

Source files
------------

// File: rtl/pc_sequencer.sv
// Run-control FSM for the fetch-stage program counter: launch, load stalls, halt, abort,
// plus a saturating execution-cycle counter reported to the test harness.
module pc_sequencer #(
  parameter logic [15:0] PROG0_START = 16'd0,
  parameter logic [15:0] PROG1_START = 16'd0,
  parameter logic [15:0] PROG2_START = 16'd0,
  parameter logic [15:0] PROG3_START = 16'd0,
  parameter int          LOAD_LAT    = 3
) (
  input  logic        CLK,
  input  logic        RST_N,
  input  logic        Start,
  input  logic [1:0]  Prog_sel,
  input  logic        Abort,
  input  logic        Dec_halt,
  input  logic        Dec_load,
  input  logic        Dec_jump,
  input  logic        Dec_bz,
  input  logic        Dec_bnz,
  input  logic [15:0] Dec_target,
  output logic        Init,
  output logic        Halt,
  output logic        Branch_abs,
  output logic        Branch_rel_z,
  output logic        Branch_rel_nz,
  output logic [15:0] Target,
  output logic        Busy,
  output logic        Done,
  output logic [15:0] Cycle_count
);

  typedef enum logic [2:0] {
    S_IDLE, S_INIT, S_LAUNCH, S_RUN, S_WAIT, S_DONE
  } state_t;

  localparam logic [3:0] LOAD_RELOAD = 4'(LOAD_LAT - 2);

  state_t      state, state_nxt;
  logic [1:0]  sel_q, sel_nxt;
  logic [3:0]  cnt, cnt_nxt;
  logic [15:0] cyc_nxt;

  function automatic logic [15:0] sat_inc(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

  function automatic logic [15:0] start_addr(input logic [1:0] s);
    case (s)
      2'd0:    return PROG0_START;
      2'd1:    return PROG1_START;
      2'd2:    return PROG2_START;
      default: return PROG3_START;
    endcase
  endfunction

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state       <= S_IDLE;
      cnt         <= '0;
      Cycle_count <= '0;
    end else begin
      state       <= state_nxt;
      cnt         <= cnt_nxt;
      Cycle_count <= cyc_nxt;
    end
  end

  // Program select is only consumed in LAUNCH, after Start has loaded it.
  always_ff @(posedge CLK) begin
    sel_q <= sel_nxt;
  end

  always_comb begin
    state_nxt     = state;
    sel_nxt       = sel_q;
    cnt_nxt       = cnt;
    cyc_nxt       = Cycle_count;
    Init          = 1'b0;
    Halt          = 1'b1;
    Branch_abs    = 1'b0;
    Branch_rel_z  = 1'b0;
    Branch_rel_nz = 1'b0;
    Target        = '0;
    if (Abort) begin
      state_nxt = S_IDLE;
      cnt_nxt   = '0;
    end else begin
      case (state)
        S_IDLE, S_DONE: begin
          if (Start) begin
            sel_nxt   = Prog_sel;
            state_nxt = S_INIT;
          end
        end
        S_INIT: begin
          Init      = 1'b1;
          Halt      = 1'b0;
          cyc_nxt   = '0;
          state_nxt = S_LAUNCH;
        end
        S_LAUNCH: begin
          Halt       = 1'b0;
          Branch_abs = 1'b1;
          Target     = start_addr(sel_q);
          state_nxt  = S_RUN;
        end
        S_RUN: begin
          cyc_nxt = sat_inc(Cycle_count);
          if (Dec_halt) begin
            state_nxt = S_DONE;
          end else if (Dec_load) begin
            cnt_nxt   = LOAD_RELOAD;
            state_nxt = S_WAIT;
          end else begin
            // One branch at a time: jump > bz > bnz.
            Halt          = 1'b0;
            Branch_abs    = Dec_jump;
            Branch_rel_z  = Dec_bz & ~Dec_jump;
            Branch_rel_nz = Dec_bnz & ~Dec_jump & ~Dec_bz;
            Target        = Dec_target;
          end
        end
        S_WAIT: begin
          cyc_nxt = sat_inc(Cycle_count);
          if (cnt != 4'd0) begin
            cnt_nxt = cnt - 4'd1;
          end else begin
            Halt      = 1'b0;
            state_nxt = S_RUN;
          end
        end
        default: state_nxt = S_IDLE;
      endcase
    end
  end

  assign Busy = (state == S_INIT) || (state == S_LAUNCH) ||
                (state == S_RUN)  || (state == S_WAIT);
  assign Done = (state == S_DONE);

endmodule

// File: tb/tb_pc_sequencer.sv
// Scoreboard bench for pc_sequencer: a PC register model follows the DUT outputs and
// per-cycle expectations are queued as stimulus is driven, then popped at the falling edge.
module tb_pc_sequencer;

  logic        CLK, RST_N, Start, Abort;
  logic [1:0]  Prog_sel;
  logic        Dec_halt, Dec_load, Dec_jump, Dec_bz, Dec_bnz;
  logic [15:0] Dec_target;
  logic        Init, Halt, Branch_abs, Branch_rel_z, Branch_rel_nz, Busy, Done;
  logic [15:0] Target, Cycle_count;
  logic [15:0] pc_m;

  int n_run  = 0;
  int n_fail = 0;

  typedef struct packed {
    logic        start;
    logic [1:0]  sel;
    logic        abort, halt, load, jump, bz, bnz;
    logic [15:0] tgt;
  } stim_t;

  typedef logic [54:0] exp_t;
  exp_t sb[$];

  pc_sequencer #(
    .PROG0_START(16'h0300), .PROG1_START(16'h0100),
    .PROG2_START(16'h0040), .PROG3_START(16'h0200), .LOAD_LAT(3)
  ) dut (
    .CLK(CLK), .RST_N(RST_N), .Start(Start), .Prog_sel(Prog_sel), .Abort(Abort),
    .Dec_halt(Dec_halt), .Dec_load(Dec_load), .Dec_jump(Dec_jump), .Dec_bz(Dec_bz),
    .Dec_bnz(Dec_bnz), .Dec_target(Dec_target), .Init(Init), .Halt(Halt),
    .Branch_abs(Branch_abs), .Branch_rel_z(Branch_rel_z), .Branch_rel_nz(Branch_rel_nz),
    .Target(Target), .Busy(Busy), .Done(Done), .Cycle_count(Cycle_count)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  // PC register driven by the sequencer; relative branches assume the condition holds.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N)                            pc_m <= '0;
    else if (Init)                         pc_m <= '0;
    else if (!Halt && Branch_abs)          pc_m <= Target;
    else if (!Halt && (Branch_rel_z || Branch_rel_nz)) pc_m <= pc_m + Target;
    else if (!Halt)                        pc_m <= pc_m + 16'd1;
  end

  exp_t obs;
  assign obs = {Init, Halt, Branch_abs, Branch_rel_z, Branch_rel_nz, Busy, Done,
                Target, Cycle_count, pc_m};

  function automatic stim_t S(input logic st, input logic [1:0] sel, input logic ab,
                              input logic hl, input logic ld, input logic jp,
                              input logic z, input logic nz, input logic [15:0] tg);
    return '{start: st, sel: sel, abort: ab, halt: hl, load: ld, jump: jp,
             bz: z, bnz: nz, tgt: tg};
  endfunction

  function automatic exp_t E(input logic in, input logic hl, input logic ba,
                             input logic z, input logic nz, input logic bsy,
                             input logic dn, input logic [15:0] tg,
                             input logic [15:0] cc, input logic [15:0] pc);
    return {in, hl, ba, z, nz, bsy, dn, tg, cc, pc};
  endfunction

  task automatic drive(input stim_t s);
    Start = s.start; Prog_sel = s.sel; Abort = s.abort;
    Dec_halt = s.halt; Dec_load = s.load; Dec_jump = s.jump;
    Dec_bz = s.bz; Dec_bnz = s.bnz; Dec_target = s.tgt;
  endtask

  task automatic test_reset();
    exp_t got, want;
    RST_N = 1'b0;
    drive(S(0, 0, 0, 0, 0, 0, 0, 0, 16'h0));
    @(posedge CLK); #1;
    sb.push_back(E(0, 1, 0, 0, 0, 0, 0, 16'h0, 16'h0, 16'h0));
    @(negedge CLK);
    got = obs; want = sb.pop_front(); n_run++;
    if (got !== want) begin
      n_fail++; $display("FAIL reset got %h expected %h", got, want);
    end
    @(posedge CLK); #1;
    RST_N = 1'b1;
    sb.push_back(E(0, 1, 0, 0, 0, 0, 0, 16'h0, 16'h0, 16'h0));
    @(negedge CLK);
    got = obs; want = sb.pop_front(); n_run++;
    if (got !== want) begin
      n_fail++; $display("FAIL reset_idle got %h expected %h", got, want);
    end
    @(posedge CLK); #1;
  endtask

  task automatic test_launch();
    stim_t st[$]; exp_t ex[$]; exp_t got, want;
    st.push_back(S(1, 2, 0, 0, 0, 0, 0, 0, 16'h0)); ex.push_back(E(0, 1, 0, 0, 0, 0, 0, 16'h0,    16'd0, 16'h0));
    st.push_back(S(0, 0, 0, 0, 0, 0, 0, 0, 16'h0)); ex.push_back(E(1, 0, 0, 0, 0, 1, 0, 16'h0,    16'd0, 16'h0));
    st.push_back(S(0, 0, 0, 0, 0, 0, 0, 0, 16'h0)); ex.push_back(E(0, 0, 1, 0, 0, 1, 0, 16'h0040, 16'd0, 16'h0));
    st.push_back(S(0, 0, 0, 0, 0, 0, 0, 0, 16'h0)); ex.push_back(E(0, 0, 0, 0, 0, 1, 0, 16'h0,    16'd0, 16'h0040));
    foreach (st[i]) begin
      drive(st[i]); sb.push_back(ex[i]);
      @(negedge CLK);
      got = obs; want = sb.pop_front(); n_run++;
      if (got !== want) begin
        n_fail++; $display("FAIL launch[%0d] got %h expected %h", i, got, want);
      end
      @(posedge CLK); #1;
    end
  endtask

  task automatic test_straight();
    stim_t st[$]; exp_t ex[$]; exp_t got, want;
    st.push_back(S(0, 0, 0, 0, 0, 0, 0, 0, 16'h1234)); ex.push_back(E(0, 0, 0, 0, 0, 1, 0, 16'h1234, 16'd1, 16'h0041));
    st.push_back(S(0, 0, 0, 0, 0, 0, 0, 0, 16'h0));    ex.push_back(E(0, 0, 0, 0, 0, 1, 0, 16'h0,    16'd2, 16'h0042));
    st.push_back(S(0, 0, 0, 0, 0, 0, 0, 0, 16'h0));    ex.push_back(E(0, 0, 0, 0, 0, 1, 0, 16'h0,    16'd3, 16'h0043));
    st.push_back(S(0, 0, 0, 0, 0, 0, 0, 0, 16'h0));    ex.push_back(E(0, 0, 0, 0, 0, 1, 0, 16'h0,    16'd4, 16'h0044));
    st.push_back(S(0, 0, 0, 1, 0, 0, 0, 0, 16'h0));    ex.push_back(E(0, 1, 0, 0, 0, 1, 0, 16'h0,    16'd5, 16'h0045));
    st.push_back(S(0, 0, 0, 0, 0, 0, 0, 0, 16'h0));    ex.push_back(E(0, 1, 0, 0, 0, 0, 1, 16'h0,    16'd6, 16'h0045));
    st.push_back(S(0, 0, 0, 0, 0, 0, 0, 0, 16'h0));    ex.push_back(E(0, 1, 0, 0, 0, 0, 1, 16'h0,    16'd6, 16'h0045));
    foreach (st[i]) begin
      drive(st[i]); sb.push_back(ex[i]);
      @(negedge CLK);
      got = obs; want = sb.pop_front(); n_run++;
      if (got !== want) begin
        n_fail++; $display("FAIL straight[%0d] got %h expected %h", i, got, want);
      end
      @(posedge CLK); #1;
    end
  endtask

  task automatic test_load();
    stim_t st[$]; exp_t ex[$]; exp_t got, want;
    st.push_back(S(1, 2, 0, 0, 0, 0, 0, 0, 16'h0));    ex.push_back(E(0, 1, 0, 0, 0, 0, 1, 16'h0,    16'd6, 16'h0045));
    st.push_back(S(0, 0, 0, 0, 0, 0, 0, 0, 16'h0));    ex.push_back(E(1, 0, 0, 0, 0, 1, 0, 16'h0,    16'd6, 16'h0045));
    st.push_back(S(0, 0, 0, 0, 0, 0, 0, 0, 16'h0));    ex.push_back(E(0, 0, 1, 0, 0, 1, 0, 16'h0040, 16'd0, 16'h0));
    st.push_back(S(0, 0, 0, 0, 0, 0, 0, 0, 16'h0));    ex.push_back(E(0, 0, 0, 0, 0, 1, 0, 16'h0,    16'd0, 16'h0040));
    st.push_back(S(0, 0, 0, 0, 0, 0, 0, 0, 16'h0));    ex.push_back(E(0, 0, 0, 0, 0, 1, 0, 16'h0,    16'd1, 16'h0041));
    st.push_back(S(0, 0, 0, 0, 1, 0, 0, 0, 16'h0));    ex.push_back(E(0, 1, 0, 0, 0, 1, 0, 16'h0,    16'd2, 16'h0042));
    st.push_back(S(0, 0, 0, 0, 0, 1, 0, 0, 16'h7777)); ex.push_back(E(0, 1, 0, 0, 0, 1, 0, 16'h0,    16'd3, 16'h0042));
    st.push_back(S(0, 0, 0, 0, 0, 0, 0, 0, 16'h0));    ex.push_back(E(0, 0, 0, 0, 0, 1, 0, 16'h0,    16'd4, 16'h0042));
    st.push_back(S(0, 0, 0, 1, 0, 0, 0, 0, 16'h0));    ex.push_back(E(0, 1, 0, 0, 0, 1, 0, 16'h0,    16'd5, 16'h0043));
    st.push_back(S(0, 0, 0, 0, 0, 0, 0, 0, 16'h0));    ex.push_back(E(0, 1, 0, 0, 0, 0, 1, 16'h0,    16'd6, 16'h0043));
    foreach (st[i]) begin
      drive(st[i]); sb.push_back(ex[i]);
      @(negedge CLK);
      got = obs; want = sb.pop_front(); n_run++;
      if (got !== want) begin
        n_fail++; $display("FAIL load[%0d] got %h expected %h", i, got, want);
      end
      @(posedge CLK); #1;
    end
  endtask

  task automatic test_branch_prio();
    stim_t st[$]; exp_t ex[$]; exp_t got, want;
    st.push_back(S(1, 2, 0, 0, 0, 0, 0, 0, 16'h0));    ex.push_back(E(0, 1, 0, 0, 0, 0, 1, 16'h0,    16'd6, 16'h0043));
    st.push_back(S(0, 0, 0, 0, 0, 0, 0, 0, 16'h0));    ex.push_back(E(1, 0, 0, 0, 0, 1, 0, 16'h0,    16'd6, 16'h0043));
    st.push_back(S(0, 0, 0, 0, 0, 0, 0, 0, 16'h0));    ex.push_back(E(0, 0, 1, 0, 0, 1, 0, 16'h0040, 16'd0, 16'h0));
    st.push_back(S(0, 0, 0, 0, 0, 1, 1, 0, 16'h0010)); ex.push_back(E(0, 0, 1, 0, 0, 1, 0, 16'h0010, 16'd0, 16'h0040));
    st.push_back(S(0, 0, 0, 0, 0, 0, 1, 1, 16'h0005)); ex.push_back(E(0, 0, 0, 1, 0, 1, 0, 16'h0005, 16'd1, 16'h0010));
    st.push_back(S(0, 0, 0, 0, 0, 0, 0, 1, 16'h0003)); ex.push_back(E(0, 0, 0, 0, 1, 1, 0, 16'h0003, 16'd2, 16'h0015));
    st.push_back(S(0, 0, 0, 1, 1, 1, 0, 0, 16'h9999)); ex.push_back(E(0, 1, 0, 0, 0, 1, 0, 16'h0,    16'd3, 16'h0018));
    st.push_back(S(0, 0, 0, 0, 0, 0, 0, 0, 16'h0));    ex.push_back(E(0, 1, 0, 0, 0, 0, 1, 16'h0,    16'd4, 16'h0018));
    foreach (st[i]) begin
      drive(st[i]); sb.push_back(ex[i]);
      @(negedge CLK);
      got = obs; want = sb.pop_front(); n_run++;
      if (got !== want) begin
        n_fail++; $display("FAIL branch_prio[%0d] got %h expected %h", i, got, want);
      end
      @(posedge CLK); #1;
    end
  endtask

  task automatic test_abort();
    stim_t st[$]; exp_t ex[$]; exp_t got, want;
    st.push_back(S(1, 1, 0, 0, 0, 0, 0, 0, 16'h0)); ex.push_back(E(0, 1, 0, 0, 0, 0, 1, 16'h0,    16'd4, 16'h0018));
    st.push_back(S(0, 0, 0, 0, 0, 0, 0, 0, 16'h0)); ex.push_back(E(1, 0, 0, 0, 0, 1, 0, 16'h0,    16'd4, 16'h0018));
    st.push_back(S(0, 0, 0, 0, 0, 0, 0, 0, 16'h0)); ex.push_back(E(0, 0, 1, 0, 0, 1, 0, 16'h0100, 16'd0, 16'h0));
    st.push_back(S(0, 0, 0, 0, 1, 0, 0, 0, 16'h0)); ex.push_back(E(0, 1, 0, 0, 0, 1, 0, 16'h0,    16'd0, 16'h0100));
    st.push_back(S(0, 0, 1, 0, 0, 0, 0, 0, 16'h0)); ex.push_back(E(0, 1, 0, 0, 0, 1, 0, 16'h0,    16'd1, 16'h0100));
    st.push_back(S(0, 0, 0, 0, 0, 0, 0, 0, 16'h0)); ex.push_back(E(0, 1, 0, 0, 0, 0, 0, 16'h0,    16'd1, 16'h0100));
    st.push_back(S(1, 3, 0, 0, 0, 0, 0, 0, 16'h0)); ex.push_back(E(0, 1, 0, 0, 0, 0, 0, 16'h0,    16'd1, 16'h0100));
    st.push_back(S(0, 0, 0, 0, 0, 0, 0, 0, 16'h0)); ex.push_back(E(1, 0, 0, 0, 0, 1, 0, 16'h0,    16'd1, 16'h0100));
    st.push_back(S(0, 0, 0, 0, 0, 0, 0, 0, 16'h0)); ex.push_back(E(0, 0, 1, 0, 0, 1, 0, 16'h0200, 16'd0, 16'h0));
    st.push_back(S(0, 0, 0, 0, 0, 0, 0, 0, 16'h0)); ex.push_back(E(0, 0, 0, 0, 0, 1, 0, 16'h0,    16'd0, 16'h0200));
    st.push_back(S(0, 0, 0, 0, 1, 0, 0, 0, 16'h0)); ex.push_back(E(0, 1, 0, 0, 0, 1, 0, 16'h0,    16'd1, 16'h0201));
    st.push_back(S(0, 0, 0, 0, 0, 0, 0, 0, 16'h0)); ex.push_back(E(0, 1, 0, 0, 0, 1, 0, 16'h0,    16'd2, 16'h0201));
    st.push_back(S(0, 0, 0, 0, 0, 0, 0, 0, 16'h0)); ex.push_back(E(0, 0, 0, 0, 0, 1, 0, 16'h0,    16'd3, 16'h0201));
    foreach (st[i]) begin
      drive(st[i]); sb.push_back(ex[i]);
      @(negedge CLK);
      got = obs; want = sb.pop_front(); n_run++;
      if (got !== want) begin
        n_fail++; $display("FAIL abort[%0d] got %h expected %h", i, got, want);
      end
      @(posedge CLK); #1;
    end
  endtask

  task automatic test_reset_in_run();
    stim_t st[$]; exp_t ex[$]; exp_t got, want;
    st.push_back(S(1, 0, 0, 0, 0, 0, 0, 0, 16'h0)); ex.push_back(E(0, 0, 0, 0, 0, 1, 0, 16'h0, 16'd4, 16'h0202));
    st.push_back(S(0, 0, 0, 0, 0, 0, 0, 0, 16'h0)); ex.push_back(E(0, 0, 0, 0, 0, 1, 0, 16'h0, 16'd5, 16'h0203));
    foreach (st[i]) begin
      drive(st[i]); sb.push_back(ex[i]);
      @(negedge CLK);
      got = obs; want = sb.pop_front(); n_run++;
      if (got !== want) begin
        n_fail++; $display("FAIL run_start_ignored[%0d] got %h expected %h", i, got, want);
      end
      @(posedge CLK); #1;
    end
    // Still in RUN here; pull reset between edges and look before any clock arrives.
    #2;
    RST_N = 1'b0;
    sb.push_back(E(0, 1, 0, 0, 0, 0, 0, 16'h0, 16'd0, 16'h0));
    #1;
    got = obs; want = sb.pop_front(); n_run++;
    if (got !== want) begin
      n_fail++; $display("FAIL async_reset got %h expected %h", got, want);
    end
    @(posedge CLK); #1;
    RST_N = 1'b1;
    sb.push_back(E(0, 1, 0, 0, 0, 0, 0, 16'h0, 16'd0, 16'h0));
    @(negedge CLK);
    got = obs; want = sb.pop_front(); n_run++;
    if (got !== want) begin
      n_fail++; $display("FAIL post_reset_idle got %h expected %h", got, want);
    end
    @(posedge CLK); #1;
  endtask

  initial begin
    test_reset();
    test_launch();
    test_straight();
    test_load();
    test_branch_prio();
    test_abort();
    test_reset_in_run();
    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end

endmodule
